instr_encoder_loader: RTL

- Encoder side of the 19-bit instruction format consumed by the processor's control unit.
- Accepts one mnemonic-level instruction per handshake (op, register fields, immediate/target) and packs it into a 19-bit word.
- Writes the packed words sequentially into instruction memory from a programmed start address.
- Used by the testbench/boot path to load programs before the core runs.

---
 rtl/instr_encoder_loader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs mnemonic-level instructions into the 19-bit control-unit word format.
// The packed words are written sequentially into instruction memory, starting
// at a programmed address. The boot path and testbenches use it to load a
// program before the core starts running.
//
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN
//   defined   : immediates that do not fit their field are rejected. The word
//               is not written and err_range is set.
//   undefined : immediates are truncated to the field width, and err_range
//               is tied to 0.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse that opens a load session (IDLE/DONE only)
//   start_addr        first write address, sampled on start
//   finish            one-cycle pulse that closes the session (LOAD only)
//   in_valid/in_ready instruction handshake
//   op, rs, rt, rd    opcode and register fields
//   imm               signed I-type immediate / unsigned J-type target
//   imem_we/addr/wdata  memory write port (addr/wdata are 0 when we=0)
//   busy, done, full  session status
//   err_illegal       sticky flag: illegal opcode seen
//   err_range         sticky flag: immediate out of range
//   words_written     number of words written in this session
//   state_dbg         current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 DONE)
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both high. in_ready is a function of registered state only, so it
// never depends on in_valid. A legal transfer shows up on the imem port
// exactly one cycle later, for exactly one cycle.
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [2:0]        rs,
   input  logic [2:0]        rt,
   input  logic [2:0]        rd,
   input  logic [16:0]       imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [18:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic              err_illegal,
   output logic              err_range,
   output logic [ADDR_W:0]   words_written,
   output logic [1:0]        state_dbg
);

   // DRAIN covers the cycle in which the final write is still on the imem
   // port. This lets done rise only after the last write has happened.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr;
   logic [18:0]       word;
   logic              legal;
   logic              is_itype;
   logic              range_ok;
   logic              fire;
   logic              wr_ok;
   logic              last;
   logic              sess_start;

   // ---------------------------------------------------------------- encoder
   always_comb begin
      word     = '0;
      legal    = 1'b1;
      is_itype = 1'b0;
      case (op)
         4'd0:  word = {4'b0000, rs, rt, rd, 3'b000, 3'b000};  // ADD
         4'd1:  word = {4'b0000, rs, rt, rd, 3'b000, 3'b010};  // SUB
         4'd2:  word = {4'b0000, rs, rt, rd, 3'b000, 3'b100};  // AND
         4'd3:  word = {4'b0000, rs, rt, rd, 3'b000, 3'b101};  // OR
         4'd4:  word = {4'b0000, rs, rt, rd, 3'b000, 3'b111};  // SLT
         4'd5:  word = {4'b0000, rs, rt, rd, 3'b000, 3'b001};  // MVZ
         4'd6:  begin word = {2'b01, 2'b00, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // ADDI
         4'd7:  begin word = {2'b01, 2'b01, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // ANDI
         4'd8:  begin word = {2'b01, 2'b10, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // LW
         4'd9:  begin word = {2'b01, 2'b11, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // LEA
         4'd10: begin word = {2'b10, 2'b00, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // SW
         4'd11: begin word = {2'b10, 2'b01, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // PCM
         4'd12: begin word = {2'b10, 2'b10, rs, rt, imm[8:0]}; is_itype = 1'b1; end  // BEQ
         4'd13: word = {2'b11, imm};                                                 // J
         default: legal = 1'b0;
      endcase
   end

`ifdef INSTR_ENC_RANGE_CHECK_EN
   // An I-type immediate fits in 9 signed bits only when bits 16..8 are all
   // copies of bit 8. A 17-bit J target is always below 2^17.
   always_comb begin
      range_ok = 1'b1;
      if (is_itype)
         range_ok = (imm[16:8] == {9{imm[8]}});
   end
`else
   always_comb begin
      range_ok = 1'b1;
      if (is_itype)
         range_ok = 1'b1;
   end
`endif

   // ------------------------------------------------------------- handshake
   assign in_ready   = (state == S_LOAD) && !full;
   assign fire       = in_valid && in_ready;
   assign wr_ok      = fire && legal && range_ok;
   assign last       = (addr == ADDR_W'(DEPTH - 1));
   assign sess_start = start && ((state == S_IDLE) || (state == S_DONE));

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_LOAD;
         S_LOAD: begin
            if (wr_ok && (last || finish))
               state_next = S_DRAIN;   // final write still on the port
            else if (finish)
               state_next = S_DONE;
         end
         S_DRAIN: state_next = S_DONE;
         S_DONE:  if (start) state_next = S_LOAD;
         default: state_next = S_IDLE;
      endcase
   end

   assign busy      = (state == S_LOAD) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

   // ------------------------------------------------------- datapath/status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we       <= 1'b0;
         imem_addr     <= '0;
         imem_wdata    <= '0;
         addr          <= '0;
         words_written <= '0;
         full          <= 1'b0;
         err_illegal   <= 1'b0;
      end else begin
         imem_we    <= wr_ok;
         imem_addr  <= wr_ok ? addr : '0;
         imem_wdata <= wr_ok ? word : '0;
         if (sess_start) begin
            addr          <= start_addr;
            words_written <= '0;
            full          <= 1'b0;
            err_illegal   <= 1'b0;
         end else begin
            if (wr_ok) begin
               words_written <= words_written + 1'b1;
               // Stop at the last word: no wrap-around into low memory.
               if (last)
                  full <= 1'b1;
               else
                  addr <= addr + 1'b1;
            end
            if (fire && !legal)
               err_illegal <= 1'b1;
         end
      end
   end

`ifdef INSTR_ENC_RANGE_CHECK_EN
   logic err_range_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_range_q <= 1'b0;
      else if (sess_start)
         err_range_q <= 1'b0;
      else if (fire && legal && !range_ok)
         err_range_q <= 1'b1;
   end
   assign err_range = err_range_q;
`else
   assign err_range = 1'b0;
`endif

endmodule
